// File: rtl/gray_pointer_rx.sv
// Receive side of a gray-coded pointer crossing: synchronizes a remote gray count,
// decodes it to binary, tracks unconsumed increments and flags illegal steps.
module gray_pointer_rx #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_cg,
    input  logic [WIDTH-1:0] i_gray,
    input  logic             i_take,
    input  logic             i_clrErr,
    output logic [WIDTH-1:0] o_rxBin,
    output logic [WIDTH-1:0] o_rdBin,
    output logic [WIDTH-1:0] o_pending,
    output logic             o_avail,
    output logic             o_incr,
    output logic             o_err
);

    localparam logic [WIDTH-1:0] One = WIDTH'(1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_gray;
    logic [WIDTH-1:0] sync_bin;
    logic [WIDTH-1:0] delta;
    logic [WIDTH-1:0] rx_bin_q;
    logic [WIDTH-1:0] rd_bin_q;
    logic [WIDTH-1:0] pending;
    logic             avail;
    logic             step_incr;
    logic             step_bad;
    logic             take_ok;
    logic             incr_q;
    logic             err_q;

    // Only sync_q[0] may see i_gray; everything downstream uses the last stage.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else if (i_cg) begin
            sync_q[0] <= i_gray;
            for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign sync_gray = sync_q[SYNC_STAGES-1];

    // bin[i] is the XOR of all gray bits at or above i.
    always_comb begin
        sync_bin = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            sync_bin[i] = ^(sync_gray >> i);
        end
    end

    always_comb begin
        delta     = sync_bin - rx_bin_q;
        step_incr = (delta == One);
        step_bad  = (delta != '0) && (delta != One);
        pending   = rx_bin_q - rd_bin_q;
        avail     = (pending != '0);
        take_ok   = i_take && avail;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_bin_q <= '0;
            rd_bin_q <= '0;
            incr_q   <= 1'b0;
            err_q    <= 1'b0;
        end else if (i_cg) begin
            rx_bin_q <= sync_bin;
            incr_q   <= step_incr;
            // A new illegal step wins over a simultaneous clear.
            err_q    <= step_bad || (err_q && !i_clrErr);
            if (take_ok) begin
                rd_bin_q <= rd_bin_q + One;
            end
        end
    end

    assign o_rxBin   = rx_bin_q;
    assign o_rdBin   = rd_bin_q;
    assign o_pending = pending;
    assign o_avail   = avail;
    assign o_incr    = incr_q;
    assign o_err     = err_q;

endmodule

// File: tb/tb_gray_pointer_rx.sv
// Self-checking bench for gray_pointer_rx: directed scenarios plus randomized traffic
// compared every cycle against a queue-based behavioural model.
module tb_gray_pointer_rx;

    localparam int W    = 3;
    localparam int S    = 2;
    localparam int MASK = (1 << W) - 1;

    logic         clk;
    logic         rst_n;
    logic         cg;
    logic [W-1:0] gray;
    logic         take;
    logic         clr_err;
    logic [W-1:0] rx_bin;
    logic [W-1:0] rd_bin;
    logic [W-1:0] pending;
    logic         avail;
    logic         incr;
    logic         err;

    int n_checks = 0;
    int n_pass   = 0;

    gray_pointer_rx #(
        .WIDTH      (W),
        .SYNC_STAGES(S)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_cg     (cg),
        .i_gray   (gray),
        .i_take   (take),
        .i_clrErr (clr_err),
        .o_rxBin  (rx_bin),
        .o_rdBin  (rd_bin),
        .o_pending(pending),
        .o_avail  (avail),
        .o_incr   (incr),
        .o_err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic logic [W-1:0] b2g(input int v);
        int t;
        t = v & MASK;
        return W'(t ^ (t >> 1));
    endfunction

    // Invert gray coding by search: the unique v whose gray code equals g.
    function automatic int g2b(input logic [W-1:0] g);
        for (int v = 0; v <= MASK; v++) begin
            if (b2g(v) == g) return v;
        end
        return 0;
    endfunction

    int           m_rx;
    int           m_rd;
    logic         m_incr;
    logic         m_err;
    logic [W-1:0] samples[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rx   <= 0;
            m_rd   <= 0;
            m_incr <= 1'b0;
            m_err  <= 1'b0;
            samples.delete();
        end else if (cg) begin : upd
            logic [W-1:0] g_old;
            int           nb;
            int           d;
            // Value seen S enabled edges ago is what the decoder presents now.
            g_old = (samples.size() >= S) ? samples[0] : '0;
            samples.push_back(gray);
            if (samples.size() > S) void'(samples.pop_front());
            nb = g2b(g_old);
            d  = (nb - m_rx) & MASK;
            m_incr <= (d == 1);
            m_err  <= (d > 1) || (m_err && !clr_err);
            if (take && (m_rx != m_rd)) m_rd <= (m_rd + 1) & MASK;
            m_rx <= nb;
        end
    end

    always @(posedge clk) begin
        #1;
        check("model_rx", int'(rx_bin), m_rx);
        check("model_rd", int'(rd_bin), m_rd);
        check("model_pending", int'(pending), (m_rx - m_rd) & MASK);
        check("model_avail", int'(avail), int'(m_rx != m_rd));
        check("model_incr", int'(incr), int'(m_incr));
        check("model_err", int'(err), int'(m_err));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int exp_incr[8] = '{0, 0, 1, 1, 1, 1, 1, 0};
    int exp_cg[4]   = '{0, 0, 1, 0};
    int seq[5]      = '{1, 3, 2, 6, 7};
    int prev_rx;
    int wrap_seen;
    int b;
    int r;

    initial begin
        rst_n   = 1'b0;
        cg      = 1'b1;
        gray    = '0;
        take    = 1'b0;
        clr_err = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("reset_rx", int'(rx_bin), 0);
        check("reset_pending", int'(pending), 0);
        check("reset_avail", int'(avail), 0);
        check("reset_err", int'(err), 0);

        // Increments 0,1,3,2,6,7: pulses after edges 3..7
        for (int i = 0; i < 8; i++) begin
            if (i < 5) gray = W'(seq[i]);
            tick();
            check("incr_latency", int'(incr), exp_incr[i]);
        end
        check("incr_end_rx", int'(rx_bin), 5);
        check("incr_end_pending", int'(pending), 5);
        check("incr_end_avail", int'(avail), 1);
        check("incr_end_err", int'(err), 0);

        // Drain with two surplus takes
        take = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            check("drain_rd", int'(rd_bin), (i < 5) ? i + 1 : 5);
        end
        take = 1'b0;
        check("drain_pending", int'(pending), 0);
        check("drain_avail", int'(avail), 0);

        // Three more increments (wrapping to 0), then asynchronous reset
        gray = 3'd5; tick();
        gray = 3'd4; tick();
        gray = 3'd0; tick();
        repeat (3) tick();
        check("pre_reset_pending", int'(pending), 3);
        check("pre_reset_err", int'(err), 0);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_rd", int'(rd_bin), 0);
        check("async_reset_pending", int'(pending), 0);
        check("async_reset_avail", int'(avail), 0);
        check("async_reset_err", int'(err), 0);
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        check("post_reset_pending", int'(pending), 0);
        check("post_reset_err", int'(err), 0);

        // Concurrent increments and takes across the wrap
        prev_rx   = 0;
        wrap_seen = 0;
        for (int i = 1; i <= 15; i++) begin
            if (i <= 10) gray = b2g(i);
            take = (i > 1);
            tick();
            check("conc_pending_le1", int'(pending <= 1), 1);
            if (prev_rx == 7 && rx_bin == 0) begin
                wrap_seen = 1;
                check("wrap_incr", int'(incr), 1);
                check("wrap_err", int'(err), 0);
            end
            prev_rx = int'(rx_bin);
        end
        take = 1'b0;
        check("wrap_seen", wrap_seen, 1);
        check("conc_rx", int'(rx_bin), 2);
        check("conc_rd", int'(rd_bin), 2);

        // Illegal jump, clear, then jump with simultaneous clear
        rst_n = 1'b0;
        gray  = '0;
        tick();
        rst_n = 1'b1;
        tick();
        gray = 3'd3;
        repeat (3) tick();
        check("err_set", int'(err), 1);
        check("err_incr", int'(incr), 0);
        check("err_rx", int'(rx_bin), 2);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("err_cleared", int'(err), 0);
        gray    = 3'd6;
        clr_err = 1'b1;
        repeat (3) tick();
        clr_err = 1'b0;
        check("err_set_wins", int'(err), 1);
        check("err_rx2", int'(rx_bin), 4);

        // Clock gate freeze
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        cg   = 1'b0;
        gray = 3'd7;
        take = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("cg_rx", int'(rx_bin), 4);
            check("cg_rd", int'(rd_bin), 0);
            check("cg_incr", int'(incr), 0);
            check("cg_err", int'(err), 0);
        end
        cg   = 1'b1;
        take = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("cg_resume_incr", int'(incr), exp_cg[i]);
        end
        check("cg_resume_rx", int'(rx_bin), 5);

        // Randomized traffic
        rst_n = 1'b0;
        gray  = '0;
        tick();
        rst_n = 1'b1;
        b     = 0;
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 45) b = b + 1;
            else if (r < 48) b = b + int'($urandom_range(2, 7));
            gray    = b2g(b);
            take    = ($urandom_range(0, 1) == 1);
            clr_err = ($urandom_range(0, 19) == 0);
            cg      = ($urandom_range(0, 9) != 0);
            tick();
        end
        cg      = 1'b1;
        take    = 1'b0;
        clr_err = 1'b0;
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
